// File: rtl/fft_pkg.sv
// Shared constants and types for the 32-point FFT front end.
package fft_pkg;
  localparam int ADC_W       = 8;
  localparam int FFT_N       = 32;
  localparam int fft_latency = 6;

  typedef enum logic {FILL, PEND} collector_state_t;
endpackage

// File: rtl/fft_valid_delay.sv
// Single-bit shift register; delays a strobe by STAGES clock edges.
module fft_valid_delay #(
  parameter int STAGES = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES:1] vld_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= d;
      for (int i = 2; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign q = vld_pipe[STAGES];
endmodule

// File: rtl/fft_frame_collector.sv
// Collects a stream of ADC samples into a parallel frame for the FFT,
// with a valid strobe aligned to the FFT pipeline output.
module fft_frame_collector
  import fft_pkg::*;
#(
  parameter int DATA_W      = ADC_W,
  parameter int N_POINTS    = FFT_N,
  parameter int FFT_LATENCY = fft_latency
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          s_data,
  input  logic                       s_valid,
  input  logic                       s_sof,
  output logic                       s_ready,
  input  logic                       frame_ready,
  output logic [N_POINTS*DATA_W-1:0] frame_out,
  output logic                       frame_valid,
  output logic                       fft_out_valid,
  output logic                       sof_err
);
  localparam int IDX_W = $clog2(N_POINTS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_POINTS - 1);

  collector_state_t                  state;
  logic [IDX_W-1:0]                  wr_idx;
  logic [N_POINTS-1:0][DATA_W-1:0]   bank;
  logic [N_POINTS-1:0][DATA_W-1:0]   bank_full;

  assign s_ready = (state == FILL) && !rst;

  // Lets the last sample go straight into frame_out on its accept edge.
  always_comb begin
    bank_full             = bank;
    bank_full[N_POINTS-1] = s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      wr_idx      <= '0;
      bank        <= '0;
      frame_out   <= '0;
      frame_valid <= 1'b0;
      sof_err     <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sof_err     <= 1'b0;
      case (state)
        FILL: if (s_valid) begin
          if (s_sof && wr_idx != '0) begin
            // Resync: drop the partial frame, this sample becomes slot 0.
            bank[0] <= s_data;
            wr_idx  <= IDX_W'(1);
            sof_err <= 1'b1;
          end else begin
            bank[wr_idx] <= s_data;
            wr_idx       <= wr_idx + 1'b1;
            if (wr_idx == LAST) begin
              if (frame_ready) begin
                frame_out   <= bank_full;
                frame_valid <= 1'b1;
              end else begin
                state <= PEND;
              end
            end
          end
        end
        PEND: if (frame_ready) begin
          frame_out   <= bank;
          frame_valid <= 1'b1;
          state       <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

  fft_valid_delay #(.STAGES(FFT_LATENCY)) u_valid_delay (
    .clk (clk),
    .rst (rst),
    .d   (frame_valid),
    .q   (fft_out_valid)
  );
endmodule

// File: tb/tb_fft_frame_collector.sv
// Randomized bench for fft_frame_collector against a queue-based frame model.
module tb_fft_frame_collector;
  localparam int W   = 8;
  localparam int N   = 32;
  localparam int LAT = 6;

  logic           clk = 1'b0;
  logic           rst, s_valid, s_sof, frame_ready;
  logic [W-1:0]   s_data;
  logic           s_ready, frame_valid, fft_out_valid, sof_err;
  logic [N*W-1:0] frame_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fft_frame_collector #(.DATA_W(W), .N_POINTS(N), .FFT_LATENCY(LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_sof         (s_sof),
    .s_ready       (s_ready),
    .frame_ready   (frame_ready),
    .frame_out     (frame_out),
    .frame_valid   (frame_valid),
    .fft_out_valid (fft_out_valid),
    .sof_err       (sof_err)
  );

  // Model: samples of the frame in progress, a pending flag, and the
  // history of frame_valid pulses used to predict fft_out_valid.
  logic [W-1:0]   cur[$];
  bit             pend;
  logic [N*W-1:0] m_frame;
  bit             m_fv, m_sof, m_fov;
  bit             fvq[$];

  task automatic check(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void load_frame();
    for (int k = 0; k < N; k++) m_frame[k*W +: W] = cur[k];
    cur.delete();
    m_fv = 1'b1;
  endfunction

  function automatic void model(input logic r, v, sof, input logic [W-1:0] d, input logic fr);
    if (r) begin
      cur.delete();
      pend    = 1'b0;
      m_frame = '0;
      m_fv    = 1'b0;
      m_sof   = 1'b0;
      m_fov   = 1'b0;
      fvq.delete();
      for (int i = 0; i < LAT; i++) fvq.push_back(1'b0);
      return;
    end
    m_fv  = 1'b0;
    m_sof = 1'b0;
    if (pend) begin
      if (fr) begin
        load_frame();
        pend = 1'b0;
      end
    end else if (v) begin
      if (sof && cur.size() != 0) begin
        cur.delete();
        cur.push_back(d);
        m_sof = 1'b1;
      end else begin
        cur.push_back(d);
        if (cur.size() == N) begin
          if (fr) load_frame();
          else    pend = 1'b1;
        end
      end
    end
    fvq.push_back(m_fv);
    m_fov = fvq.pop_front();
  endfunction

  task automatic cycle(input logic r, v, sof, input logic [W-1:0] d, input logic fr);
    rst = r; s_valid = v; s_sof = sof; s_data = d; frame_ready = fr;
    model(r, v, sof, d, fr);
    @(posedge clk);
    @(negedge clk);
    check("s_ready",       s_ready,       !r && !pend);
    check("frame_out",     frame_out,     m_frame);
    check("frame_valid",   frame_valid,   m_fv);
    check("fft_out_valid", fft_out_valid, m_fov);
    check("sof_err",       sof_err,       m_sof);
  endtask

  function automatic logic [W-1:0] extreme();
    case ($urandom_range(0, 2))
      0:       return 8'h7f;
      1:       return 8'h80;
      default: return 8'h81;
    endcase
  endfunction

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = '0; frame_ready = 1'b0;
    @(negedge clk);
    repeat (2) cycle(1, 0, 0, 8'h00, 1);

    // Ramp -16..15, dense, consumer always ready.
    for (int i = 0; i < N; i++) cycle(0, 1, i == 0, W'(i - 16), 1);
    repeat (8) cycle(0, 0, 0, 8'h00, 1);

    // Backpressure on the last sample, released 5 cycles later.
    for (int i = 0; i < N; i++) cycle(0, 1, i == 0, W'($urandom), i != N - 1);
    repeat (5) cycle(0, 1, 0, W'($urandom), 0);
    cycle(0, 1, 0, W'($urandom), 1);
    for (int i = 0; i < N; i++) cycle(0, 1, i == 0, W'($urandom), 1);
    repeat (8) cycle(0, 0, 0, 8'h00, 1);

    // Mid-frame sof on sample 10, then 31 more samples complete the frame.
    for (int i = 0; i < 10; i++) cycle(0, 1, i == 0, W'($urandom), 1);
    cycle(0, 1, 1, 8'h5a, 1);
    for (int i = 0; i < N - 1; i++) cycle(0, 1, 0, W'($urandom), 1);
    repeat (8) cycle(0, 0, 0, 8'h00, 1);

    // Sparse valid with extreme signed values.
    for (int i = 0; i < 2 * N; i++) cycle(0, i[0] == 1'b0, 1'b0, extreme(), 1);
    repeat (8) cycle(0, 0, 0, 8'h00, 1);

    // Reset after 20 samples, then a clean frame.
    for (int i = 0; i < 20; i++) cycle(0, 1, i == 0, W'($urandom), 1);
    cycle(1, 1, 0, W'($urandom), 1);
    for (int i = 0; i < N; i++) cycle(0, 1, i == 0, W'($urandom), 1);
    // Reset 3 cycles after frame_valid, inside the delay window.
    repeat (2) cycle(0, 0, 0, 8'h00, 1);
    cycle(1, 0, 0, 8'h00, 1);
    repeat (10) cycle(0, 0, 0, 8'h00, 1);
    for (int i = 0; i < N; i++) cycle(0, 1, i == 0, W'($urandom), 1);
    repeat (8) cycle(0, 0, 0, 8'h00, 1);

    // Random traffic, including PEND stretches, stray sof and resets.
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 999) < 3,
            $urandom_range(0, 99) < 70,
            $urandom_range(0, 99) < 3,
            W'($urandom),
            $urandom_range(0, 99) < 70);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
